ctrl_spi_rx_fifo: RTL and testbench
===================================

# ctrl_spi_rx_fifo

Byte-level front end for the control unit. It receives command and payload bytes from the host MCU over a mode-0 SPI slave link and buffers them in a small FIFO. It presents the head byte as `out_byte`/`out_valid` to the controller's `in_byte`/`in_valid`, and pops one entry for each single-cycle `next` pulse the controller issues. It decouples SPI bit timing from the controller's one-byte-per-two-cycles consumption.

## Interface
- `FIFO_DEPTH`, 16: number of byte entries; power of two, ≥ 4.
- `SYNC_STAGES`, 2: synchronizer flops on `spi_sck`, `spi_cs_n`, `spi_mosi`; ≥ 2.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high; clock `clk`.
- `spi_sck`  in  1  SPI clock, asynchronous, idle low.
- `spi_cs_n`  in  1  chip select, active-low, asynchronous.
- `spi_mosi`  in  1  serial data in, MSB first.
- `spi_miso`  out  1  serial data out (see Configuration).
- `out_byte`  out  8  FIFO head byte; 8'h00 whenever `out_valid`=0.
- `out_valid`  out  1  FIFO non-empty.
- `next`  in  1  pop strobe from the controller; one entry per cycle high.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; a received byte was dropped because the FIFO was full.
- `frame_error`  out  1  one-cycle pulse; CS rose with 1–7 bits shifted.

## Operation
- Synchronizer: each SPI input passes through `SYNC_STAGES` flops. Edge detection uses one further registered copy.
- Shifter: on a synchronized `spi_sck` rising edge while synchronized `spi_cs_n`=0, shift `mosi` into an 8-bit register MSB first and increment a 3-bit bit counter.
- When the 8th bit is sampled (counter wraps 7→0), raise a push request carrying the completed byte.
- On a synchronized `spi_cs_n` rising edge:
  - if the bit counter ≠ 0, discard the partial byte, clear the counter and pulse `frame_error`;
  - if the counter = 0, take no action.
- While `spi_cs_n`=1, ignore `spi_sck` edges. On a CS falling edge, clear the bit counter.
- FIFO is circular with `rd_ptr`/`wr_ptr` of width $clog2(FIFO_DEPTH)+1; empty/full are derived from the pointers.
  - Push while not full: write the entry and increment `wr_ptr`.
  - Push while full: drop the byte, set `overflow`. Pointers are unchanged.
  - `next` while `out_valid`=1: increment `rd_ptr`.
  - `next` while empty: ignored, no underflow.
  - Simultaneous push and pop: both take effect and `fifo_level` is unchanged. Push is accepted even when full if a pop occurs in the same cycle.
- `out_byte` is registered and reflects the entry at `rd_ptr` after any pop in the current cycle.
- `overflow` clears only on `reset`.
- Reset values:
  - all pointers, bit counter and shift register 0;
  - `out_byte`=8'h00, `out_valid`=0, `fifo_level`=0;
  - `overflow`=0, `frame_error`=0, `spi_miso`=0.
- Reset mid-byte discards the partial byte. After reset the shifter waits for a CS falling edge before accepting bits.

## Timing
- Pin-to-sample latency: `SYNC_STAGES`+1 clk cycles from an `spi_sck` rising pin edge.
- 8th bit sampled in cycle t → FIFO written at t+1 → `out_valid`/`out_byte` visible at t+2.
- `next` high in cycle t → `out_byte`, `out_valid` and `fifo_level` update at t+1.
- Back-to-back `next` pulses on consecutive cycles pop consecutive entries. A controller gap cycle is not required.
- `spi_sck` high and low phases must each be ≥ `SYNC_STAGES`+2 clk cycles. CS setup and hold around the first and last SCK edge must be ≥ `SYNC_STAGES`+2 clk cycles.
- `frame_error` is asserted `SYNC_STAGES`+1 cycles after the CS rising pin edge and lasts exactly one cycle.

## Configuration
- `CTRL_SPI_STATUS_ECHO_EN` defined:
  - On each byte boundary (CS falling edge, or the 8th bit sampled), load the status byte {`overflow`, frame_error_sticky, level_sat[5:0]}, where level_sat = min(`fifo_level`, 63).
  - frame_error_sticky is set by any `frame_error` pulse and cleared by `reset`.
  - Shift the status byte out MSB first on `spi_miso`, updating on synchronized SCK falling edges. `spi_miso`=0 while CS is high.
- `CTRL_SPI_STATUS_ECHO_EN` undefined: `spi_miso` is tied to 0 and no status logic is built.

## Test plan
- Reset, then one CS frame sending 8'hA5 → 2 cycles after the 8th sampled bit, `out_valid`=1, `out_byte`=8'hA5, `fifo_level`=1. One `next` pulse → `out_valid`=0, `out_byte`=8'h00.
- Frame of 8'h03, 8'h12, 8'h34 with `next` held off, then `next` pulsed on 3 consecutive cycles → bytes appear in order 03, 12, 34, then empty.
- DEPTH=16: send 17 bytes without popping → `fifo_level`=16, `overflow`=1, 17th byte absent. Drain 16 bytes → `overflow` remains 1.
- CS rises after 5 bits → one `frame_error` pulse and no push. The next full frame 8'h7E is received intact.
- FIFO full with push and `next` in the same cycle → level stays 16, no overflow, new byte present at the tail.
- With `CTRL_SPI_STATUS_ECHO_EN` and 3 bytes buffered, start a frame → MISO returns 8'b0000_0011 MSB first.

Source files
------------

// File: rtl/ctrl_spi_rx_fifo.sv
// SPI mode-0 slave receiver feeding a byte FIFO for the control unit.
// Define CTRL_SPI_STATUS_ECHO_EN to echo a status byte on spi_miso.
`timescale 1ns/1ps
module ctrl_spi_rx_fifo #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          spi_sck,
  input  logic                          spi_cs_n,
  input  logic                          spi_mosi,
  output logic                          spi_miso,
  output logic [7:0]                    out_byte,
  output logic                          out_valid,
  input  logic                          next,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int W  = AW + 1;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic sck_d;
  logic cs_d;
  logic sck_s;
  logic cs_s;
  logic mosi_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  logic sck_rise;
  logic cs_fall;
  logic cs_rise;
  logic sample;
  logic last_bit;

  assign sck_rise = sck_s & ~sck_d;
  assign cs_fall  = cs_d & ~cs_s;
  assign cs_rise  = ~cs_d & cs_s;

  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       armed;
  logic       push_req;

  // armed keeps the shifter idle after reset until a fresh frame starts
  assign sample   = sck_rise & ~cs_s & armed;
  assign last_bit = sample & (bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg       <= 8'h00;
      bit_cnt     <= 3'd0;
      armed       <= 1'b0;
      push_req    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      push_req    <= 1'b0;
      frame_error <= 1'b0;
      if (cs_fall) begin
        bit_cnt <= 3'd0;
        armed   <= 1'b1;
      end else if (cs_rise) begin
        if (bit_cnt != 3'd0) frame_error <= 1'b1;
        bit_cnt <= 3'd0;
      end else if (sample) begin
        shreg   <= {shreg[6:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (last_bit) push_req <= 1'b1;
      end
    end
  end

  logic [7:0]   mem [FIFO_DEPTH];
  logic [W-1:0] rd_ptr;
  logic [W-1:0] wr_ptr;
  logic [W-1:0] rd_n;
  logic [W-1:0] wr_n;
  logic         empty;
  logic         full;
  logic         pop;
  logic         push_ok;
  logic [7:0]   head_n;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = ((rd_ptr ^ wr_ptr) == {1'b1, {AW{1'b0}}});
  assign pop   = next & out_valid;
  // a pop frees a slot in the same cycle, so a full FIFO still accepts
  assign push_ok = push_req & (~full | pop);
  assign rd_n  = rd_ptr + {{AW{1'b0}}, pop};
  assign wr_n  = wr_ptr + {{AW{1'b0}}, push_ok};
  assign fifo_level = wr_ptr - rd_ptr;

  always_comb begin
    head_n = mem[rd_n[AW-1:0]];
    if (rd_n == wr_n)
      head_n = 8'h00;
    else if (push_ok && rd_n == wr_ptr)
      head_n = shreg;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      out_byte  <= 8'h00;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      rd_ptr    <= rd_n;
      wr_ptr    <= wr_n;
      out_byte  <= head_n;
      out_valid <= (rd_n != wr_n);
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

`ifdef CTRL_SPI_STATUS_ECHO_EN
  localparam int LW = (W > 6) ? W : 6;

  logic          sck_fall;
  logic          fe_sticky;
  logic [7:0]    tx_sr;
  logic          miso_q;
  logic [LW-1:0] lvl_ext;
  logic [5:0]    level_sat;

  assign sck_fall  = ~sck_s & sck_d;
  assign lvl_ext   = LW'(fifo_level);
  assign level_sat = (lvl_ext > LW'(63)) ? 6'h3f : lvl_ext[5:0];

  // no shift on the falling edge right after a reload (bit_cnt is 0)
  always_ff @(posedge clk) begin
    if (reset) begin
      fe_sticky <= 1'b0;
      tx_sr     <= 8'h00;
      miso_q    <= 1'b0;
    end else begin
      if (frame_error) fe_sticky <= 1'b1;
      if (cs_fall || last_bit)
        tx_sr <= {overflow, fe_sticky, level_sat};
      else if (sck_fall && !cs_s && bit_cnt != 3'd0)
        tx_sr <= {tx_sr[6:0], 1'b0};
      miso_q <= ~cs_s & tx_sr[7];
    end
  end

  assign spi_miso = miso_q;
`else
  assign spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_spi_rx_fifo.sv
// Directed bench for ctrl_spi_rx_fifo: framing, FIFO order, full/overflow.
`timescale 1ns/1ps
module tb_ctrl_spi_rx_fifo;

  localparam int HALF = 6;
`ifdef CTRL_SPI_STATUS_ECHO_EN
  localparam logic [7:0] ECHO3 = 8'h03;
`else
  localparam logic [7:0] ECHO3 = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       next;
  logic [4:0] fifo_level;
  logic       overflow;
  logic       frame_error;

  int n_cmp = 0;
  int n_bad = 0;
  int fe_cnt = 0;

  ctrl_spi_rx_fifo #(.FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .out_byte(out_byte), .out_valid(out_valid),
    .next(next), .fifo_level(fifo_level),
    .overflow(overflow), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_error === 1'b1) fe_cnt <= fe_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    cyc(HALF);
    m = spi_miso;
    spi_sck = 1'b1;
    cyc(HALF);
    spi_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] m);
    for (int i = 7; i >= 0; i--) spi_bit(b[i], m[i]);
  endtask

  // seven bits, then the 8th rising edge; returns 3 cycles after it
  task automatic spi_byte_hold(input logic [7:0] b);
    logic m;
    for (int i = 7; i >= 1; i--) spi_bit(b[i], m);
    spi_mosi = b[0];
    cyc(HALF);
    spi_sck = 1'b1;
    cyc(3);
  endtask

  task automatic cs_lo();
    spi_cs_n = 1'b0;
    cyc(HALF);
  endtask

  task automatic cs_hi();
    cyc(HALF);
    spi_cs_n = 1'b1;
    cyc(HALF);
  endtask

  task automatic pop();
    next = 1'b1;
    cyc(1);
    next = 1'b0;
  endtask

  initial begin
    logic [7:0] m;
    logic       mb;
    int         fe0;
    reset = 1'b1;
    spi_sck = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    next = 1'b0;
    cyc(3);
    chk("rst_valid", out_valid, 0);
    chk("rst_byte", out_byte, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_fe", frame_error, 0);
    chk("rst_miso", spi_miso, 0);
    reset = 1'b0;
    cyc(2);

    // single byte with exact push latency
    cs_lo();
    spi_byte_hold(8'hA5);
    chk("a5_early_valid", out_valid, 0);
    cyc(1);
    chk("a5_valid", out_valid, 1);
    chk("a5_byte", out_byte, 8'hA5);
    chk("a5_level", fifo_level, 1);
    cyc(HALF - 4);
    spi_sck = 1'b0;
    cs_hi();
    pop();
    chk("a5_pop_valid", out_valid, 0);
    chk("a5_pop_byte", out_byte, 0);
    chk("a5_pop_level", fifo_level, 0);

    // three bytes, status echo, back-to-back pops
    cs_lo();
    spi_byte(8'h03, m);
    spi_byte(8'h12, m);
    spi_byte(8'h34, m);
    cs_hi();
    chk("tri_level", fifo_level, 3);
    chk("tri_head", out_byte, 8'h03);
    cs_lo();
    spi_byte(8'h55, m);
    cs_hi();
    chk("echo_miso", m, ECHO3);
    chk("echo_level", fifo_level, 4);
    next = 1'b1;
    cyc(1);
    chk("b2b_1", out_byte, 8'h12);
    cyc(1);
    chk("b2b_2", out_byte, 8'h34);
    cyc(1);
    chk("b2b_3", out_byte, 8'h55);
    cyc(1);
    chk("b2b_empty_byte", out_byte, 0);
    chk("b2b_empty_valid", out_valid, 0);
    next = 1'b0;
    pop();
    chk("underflow_level", fifo_level, 0);
    chk("underflow_valid", out_valid, 0);
    chk("idle_miso", spi_miso, 0);

    // full FIFO with push and pop in the same cycle
    cs_lo();
    for (int i = 0; i < 16; i++) spi_byte(8'h40 + 8'(i), m);
    chk("full_level", fifo_level, 16);
    chk("full_ovf", overflow, 0);
    chk("full_head", out_byte, 8'h40);
    spi_byte_hold(8'hC3);
    next = 1'b1;
    cyc(1);
    next = 1'b0;
    chk("pp_level", fifo_level, 16);
    chk("pp_ovf", overflow, 0);
    chk("pp_head", out_byte, 8'h41);
    cyc(HALF - 4);
    spi_sck = 1'b0;
    cs_hi();
    for (int i = 0; i < 16; i++) begin
      chk("pp_drain", out_byte, (i < 15) ? 8'h41 + 8'(i) : 8'hC3);
      pop();
    end
    chk("pp_drained", out_valid, 0);

    // overflow: 17 bytes, last one dropped
    cs_lo();
    for (int i = 0; i < 17; i++) spi_byte(8'h60 + 8'(i), m);
    cs_hi();
    chk("ovf_level", fifo_level, 16);
    chk("ovf_flag", overflow, 1);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain", out_byte, 8'h60 + 8'(i));
      pop();
    end
    chk("ovf_no17", out_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // short frame, then a clean frame
    fe0 = fe_cnt;
    cs_lo();
    for (int i = 0; i < 5; i++) spi_bit(1'b1, mb);
    cs_hi();
    cyc(4);
    chk("fe_pulses", fe_cnt - fe0, 1);
    chk("fe_nopush", fifo_level, 0);
    cs_lo();
    spi_byte(8'h7E, m);
    cs_hi();
    chk("after_fe_level", fifo_level, 1);
    chk("after_fe_byte", out_byte, 8'h7E);
    chk("after_fe_pulses", fe_cnt - fe0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
